// File: rtl/dma_cpu_bus_master.sv
// CPU-side programming master for the 8237A register interface.
// Turns one request into one or three CS_N/IOR_N/IOW_N byte cycles.
module dma_cpu_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic [3:0]  REQ_ADDR,
    input  logic        REQ_WIDE,
    input  logic [15:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [15:0] RSP_RDATA,
    output logic        RSP_ERR,
    input  logic        HLDA,
    output logic        CS_N,
    output logic        IOR_N,
    output logic        IOW_N,
    output logic [3:0]  ADDR_L,
    output logic [7:0]  DB_OUT,
    output logic        DB_OE,
    input  logic [7:0]  DB_IN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_GAP,
        S_RESP
    } state_t;

    localparam logic [7:0] L_SETUP  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] L_STROBE = 8'(STROBE_CYC - 1);
    localparam logic [7:0] L_HOLD   = 8'(HOLD_CYC - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [1:0]  r_idx;
    logic [1:0]  r_last;
    logic        r_write;
    logic        r_wide;
    logic        r_err;
    logic        r_armed;
    logic [3:0]  r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;

    logic        w_accept;
    logic        w_busy;
    logic        w_abort;
    logic        w_done;
    logic        w_cbp;
    logic        w_hi;
    logic        w_bwr;
    logic [3:0]  w_baddr;
    logic [7:0]  w_bdata;

    assign w_accept = REQ_VALID && REQ_READY;
    assign w_busy   = (r_state == S_SETUP) || (r_state == S_STROBE) ||
                      (r_state == S_HOLD);
    assign w_abort  = w_busy && HLDA;

    // Byte 0 of a wide access is the clear-byte-pointer write.
    assign w_cbp   = r_wide && (r_idx == 2'd0);
    assign w_hi    = r_wide && (r_idx == 2'd2);
    assign w_bwr   = w_cbp || r_write;
    assign w_baddr = w_cbp ? 4'hC : r_addr;
    assign w_bdata = w_cbp ? 8'h00 :
                     w_hi  ? r_wdata[15:8] : r_wdata[7:0];

    always_comb begin
        w_done = 1'b0;
        case (r_state)
            S_SETUP:  w_done = (r_cnt == L_SETUP);
            S_STROBE: w_done = (r_cnt == L_STROBE);
            S_HOLD:   w_done = (r_cnt == L_HOLD);
            default:  w_done = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = HLDA ? S_WAIT_BUS : S_SETUP;
            end
            S_WAIT_BUS: begin
                if (!HLDA)
                    w_next = S_SETUP;
            end
            S_SETUP: begin
                if (w_abort)
                    w_next = S_RESP;
                else if (w_done)
                    w_next = S_STROBE;
            end
            S_STROBE: begin
                if (w_abort)
                    w_next = S_RESP;
                else if (w_done)
                    w_next = S_HOLD;
            end
            S_HOLD: begin
                if (w_abort)
                    w_next = S_RESP;
                else if (w_done)
                    w_next = (r_idx == r_last) ? S_RESP : S_GAP;
            end
            S_GAP: begin
                w_next = HLDA ? S_WAIT_BUS : S_SETUP;
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= 2'd0;
            r_last  <= 2'd0;
            r_write <= 1'b0;
            r_wide  <= 1'b0;
            r_err   <= 1'b0;
            r_armed <= 1'b0;
            r_addr  <= 4'd0;
            r_wdata <= 16'd0;
            r_rdata <= 16'd0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
            if (w_next != r_state)
                r_cnt <= 8'd0;
            else if (w_busy)
                r_cnt <= r_cnt + 8'd1;
            if (w_accept) begin
                r_write <= REQ_WRITE;
                r_addr  <= REQ_ADDR;
                r_wdata <= REQ_WDATA;
                r_wide  <= REQ_WIDE && !REQ_ADDR[3];
                r_last  <= (REQ_WIDE && !REQ_ADDR[3]) ? 2'd2 : 2'd0;
                r_idx   <= 2'd0;
                r_err   <= 1'b0;
                r_rdata <= 16'd0;
            end
            if (r_state == S_HOLD && w_next == S_GAP)
                r_idx <= r_idx + 2'd1;
            // Read data is taken on the closing edge of the strobe.
            if (r_state == S_STROBE && w_done && !w_abort && !w_bwr) begin
                if (w_hi)
                    r_rdata[15:8] <= DB_IN;
                else
                    r_rdata[7:0] <= DB_IN;
            end
            if (w_abort) begin
                r_err   <= 1'b1;
                r_rdata <= 16'd0;
            end
        end
    end

    assign REQ_READY = (r_state == S_IDLE) && r_armed;
    assign CS_N      = !w_busy;
    assign IOR_N     = !((r_state == S_STROBE) && !w_bwr);
    assign IOW_N     = !((r_state == S_STROBE) && w_bwr);
    assign ADDR_L    = w_busy ? w_baddr : 4'h0;
    assign DB_OUT    = (w_busy && w_bwr) ? w_bdata : 8'h00;
    assign DB_OE     = w_busy && w_bwr;
    assign RSP_VALID = (r_state == S_RESP);
    assign RSP_RDATA = (r_state == S_RESP) ? r_rdata : 16'h0000;
    assign RSP_ERR   = (r_state == S_RESP) && r_err;

endmodule
